// File: rtl/multiplier_unit_if.sv
// rtl/multiplier_unit_if.sv - operand/result handshake bundle for multiplier_unit
interface multiplier_unit_if #(
  parameter int parallelism = 32
);
  logic                       start;
  logic                       usigned_n;
  logic [parallelism-1:0]     multiplicand;
  logic [parallelism-1:0]     multiplier;
  logic [2*parallelism-1:0]   product;
  logic                       busy;
  logic                       done;

  modport master (
    output start, usigned_n, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, usigned_n, multiplicand, multiplier,
    output product, busy, done
  );
endinterface

// File: rtl/multiplier_unit.sv
// rtl/multiplier_unit.sv - radix-2 shift-add multiplier, signed/unsigned, one bit per cycle
module multiplier_unit #(
  parameter int parallelism = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  multiplier_unit_if.slave  mul_if
);
  localparam int CW = $clog2(parallelism + 1);
  localparam logic [parallelism+1:0] SUM_ONE = {{(parallelism+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [parallelism-1:0]     mcand_q, mcand_d;
  logic                       mode_q, mode_d;
  logic [parallelism:0]       hi_q, hi_d;
  logic [parallelism-1:0]     lo_q, lo_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [2*parallelism-1:0]   product_q, product_d;

  logic [parallelism:0]       mcand_ext, addend;
  logic [parallelism+1:0]     sum;
  logic                       last_iter, sub_en, shift_msb, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mode_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mode_q    <= mode_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // The multiplier MSB carries negative weight in signed mode, so the last step subtracts.
  always_comb begin
    mcand_ext = {mode_q & mcand_q[parallelism-1], mcand_q};
    last_iter = (cnt_q == CW'(1));
    sub_en    = mode_q & last_iter & lo_q[0];
    addend    = lo_q[0] ? mcand_ext : '0;
    if (sub_en) begin
      sum = {1'b0, hi_q} + {1'b0, ~mcand_ext} + SUM_ONE;
    end else begin
      sum = {1'b0, hi_q} + {1'b0, addend};
    end
    shift_msb = mode_q ? sum[parallelism] : sum[parallelism+1];
    accept    = mul_if.start & (state_q != RUN);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_if.start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = mul_if.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d   = mcand_q;
    mode_d    = mode_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (accept) begin
      mcand_d = mul_if.multiplicand;
      mode_d  = mul_if.usigned_n;
      hi_d    = '0;
      lo_d    = mul_if.multiplier;
      cnt_d   = CW'(parallelism);
    end else if (state_q == RUN) begin
      hi_d  = {shift_msb, sum[parallelism:1]};
      lo_d  = {sum[0], lo_q[parallelism-1:1]};
      cnt_d = cnt_q - CW'(1);
      if (last_iter) begin
        product_d = {sum[parallelism:0], lo_q[parallelism-1:1]};
      end
    end
  end

  always_comb begin
    mul_if.busy    = (state_q == RUN);
    mul_if.done    = (state_q == DONE);
    mul_if.product = product_q;
  end
endmodule

// File: tb/tb_multiplier_unit.sv
// tb/tb_multiplier_unit.sv - randomized self-checking bench for multiplier_unit
module tb_multiplier_unit;
  localparam int P = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  multiplier_unit_if #(.parallelism(P)) mul_if ();

  multiplier_unit #(.parallelism(P)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mul_if (mul_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic s);
    mul_if.multiplicand = a;
    mul_if.multiplier   = b;
    mul_if.usigned_n    = s;
  endtask

  // Caller is just after an edge ("edge 0"); start is sampled on the following edge.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    int edges;
    logic [63:0] exp;
    exp = ref_prod(a, b, s);
    set_ops(a, b, s);
    mul_if.start = 1'b1;
    tick();
    edges = 1;
    mul_if.start = 1'b0;
    check_eq({tag, "_busy"}, 64'(mul_if.busy), 64'd1);
    while (!mul_if.done && edges < 200) begin
      tick();
      edges++;
    end
    check_eq({tag, "_lat"}, 64'(edges), 64'(P + 1));
    check_eq({tag, "_prod"}, mul_if.product, exp);
    tick();
    check_eq({tag, "_done_pulse"}, 64'(mul_if.done), 64'd0);
    check_eq({tag, "_hold"}, mul_if.product, exp);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          dones, busy_drop, edges;
    logic [63:0] first_prod;

    mul_if.start = 1'b0;
    set_ops('0, '0, 1'b0);
    repeat (3) tick();
    check_eq("rst_prod", mul_if.product, 64'd0);
    check_eq("rst_busy", 64'(mul_if.busy), 64'd0);
    check_eq("rst_done", 64'(mul_if.done), 64'd0);
    rst_n = 1'b1;
    tick();

    do_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("umax_const", mul_if.product, 64'hFFFF_FFFE_0000_0001);
    do_op("smix", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
    check_eq("smix_const", mul_if.product, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op("sm1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check_eq("sm1m1_const", mul_if.product, 64'h1);
    do_op("sminmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check_eq("sminmin_const", mul_if.product, 64'h4000_0000_0000_0000);
    do_op("smin1", 32'h8000_0000, 32'h0000_0001, 1'b1);
    check_eq("smin1_const", mul_if.product, 64'hFFFF_FFFF_8000_0000);
    do_op("zero_a", 32'h0, 32'h1234_5678, 1'b1);
    do_op("zero_b", 32'hDEAD_BEEF, 32'h0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      a = $urandom();
      b = $urandom();
      s = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d", i), a, b, s);
    end

    // start with new operands mid-RUN must be ignored
    a = $urandom();
    b = $urandom();
    set_ops(a, b, 1'b1);
    mul_if.start = 1'b1;
    tick();
    mul_if.start = 1'b0;
    dones = 0;
    busy_drop = 0;
    first_prod = '0;
    for (int e = 1; e < P + 10; e++) begin
      if (e == 10) begin
        set_ops(~a, b ^ 32'h5555_5555, 1'b0);
        mul_if.start = 1'b1;
      end else begin
        mul_if.start = 1'b0;
      end
      if (mul_if.done) begin
        dones++;
        first_prod = mul_if.product;
      end else if (dones == 0 && !mul_if.busy) begin
        busy_drop++;
      end
      tick();
    end
    mul_if.start = 1'b0;
    check_eq("ign_dones", 64'(dones), 64'd1);
    check_eq("ign_busy", 64'(busy_drop), 64'd0);
    check_eq("ign_prod", first_prod, ref_prod(a, b, 1'b1));

    // back-to-back: start held through DONE
    a = $urandom();
    b = $urandom();
    set_ops(a, b, 1'b0);
    mul_if.start = 1'b1;
    tick();
    edges = 1;
    while (!mul_if.done && edges < 200) begin
      tick();
      edges++;
    end
    check_eq("b2b_lat1", 64'(edges), 64'(P + 1));
    check_eq("b2b_prod1", mul_if.product, ref_prod(a, b, 1'b0));
    a = $urandom();
    b = $urandom();
    set_ops(a, b, 1'b1);
    tick();
    mul_if.start = 1'b0;
    edges = 1;
    check_eq("b2b_busy", 64'(mul_if.busy), 64'd1);
    check_eq("b2b_done_low", 64'(mul_if.done), 64'd0);
    while (!mul_if.done && edges < 200) begin
      tick();
      edges++;
    end
    check_eq("b2b_lat2", 64'(edges), 64'(P + 1));
    check_eq("b2b_prod2", mul_if.product, ref_prod(a, b, 1'b1));
    tick();

    // reset mid-RUN aborts with no done
    set_ops($urandom(), $urandom(), 1'b0);
    mul_if.start = 1'b1;
    tick();
    mul_if.start = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    check_eq("mrst_prod", mul_if.product, 64'd0);
    check_eq("mrst_busy", 64'(mul_if.busy), 64'd0);
    check_eq("mrst_done", 64'(mul_if.done), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int e = 0; e < P + 5; e++) begin
      tick();
      if (mul_if.done) dones++;
    end
    check_eq("mrst_nodone", 64'(dones), 64'd0);
    check_eq("mrst_prod_after", mul_if.product, 64'd0);
    do_op("post_rst", $urandom(), $urandom(), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/multiplier_unit.md
MULTIPLIER_UNIT -- requirements
Module: multiplier_unit

Interface
REQ-001 Parameter parallelism, default 32, sets the operand width in bits; legal range is 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 start  input  1  request a new multiplication; sampled on rising edge.
REQ-005 usigned_n  input  1  0 = operands unsigned, 1 = operands two's-complement signed; sampled with start.
REQ-006 multiplicand  input  parallelism  operand A; sampled with start.
REQ-007 multiplier  input  parallelism  operand B; sampled with start.
REQ-008 product  output  2*parallelism  registered result A*B.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle pulse marking a new valid product.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL be accepted: latch operands and usigned_n, clear the accumulator, load the iteration counter with parallelism, and move to RUN.
REQ-013 In DONE with start=0, the FSM SHALL return to IDLE on the next edge.
REQ-014 While in RUN, start SHALL be ignored; latched operands and mode SHALL NOT change.
REQ-015 Algorithm: radix-2 shift-add, one multiplier bit per cycle, LSB first.
- Accumulator high half: parallelism+1 bits. Low half: the shifting multiplier register.
REQ-016 Each RUN cycle: if the current multiplier LSB=1, add the multiplicand to the high half; then shift {high,low} right by one.
- Multiplicand extension to parallelism+1 bits: zero-extend if usigned_n=0, sign-extend if usigned_n=1.
- Shifted-in MSB: the adder carry-out if usigned_n=0, the arithmetic sign of the sum if usigned_n=1.
REQ-017 Signed mode, final iteration (multiplier MSB): the multiplicand SHALL be subtracted instead of added when that bit is 1.
REQ-018 A counter SHALL decrement once per RUN cycle; on terminal count, the FSM SHALL move to DONE.
- RUN lasts exactly parallelism cycles.
REQ-019 On the RUN->DONE edge, product SHALL load the low 2*parallelism accumulator bits.
- product SHALL hold that value until the next RUN->DONE edge or reset.
- product SHALL NOT change during RUN.
REQ-020 Latency: if start is accepted at edge 0, done=1 and the new product are visible after edge parallelism+1.
REQ-021 busy SHALL be 1 exactly while the state is RUN.
REQ-022 done SHALL be 1 exactly while the state is DONE (one cycle per operation).
REQ-023 Start accepted in DONE (back-to-back): done SHALL still be high that cycle; the next operation follows with the same latency.
REQ-024 Zero operand, either side: still SHALL take the full latency and produce 0.
REQ-025 The result SHALL be exact for all operand pairs in both modes; no overflow is possible.

Reset
REQ-026 While rst_n=0: state=IDLE, product=0, busy=0, done=0, counter and accumulator=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
- After release, the block SHALL accept a new start normally.

Verification (parallelism=32)
REQ-028 Unsigned max: usigned_n=0, A=B=0xFFFFFFFF, start at edge 0 -> done at edge 33, product=0xFFFFFFFE00000001.
REQ-029 Signed mix: usigned_n=1, A=0xFFFFFFFD (-3), B=0x00000005 -> product=0xFFFFFFFFFFFFFFF1.
REQ-030 Signed corners:
- (-1)*(-1) -> 0x0000000000000001.
- 0x80000000*0x80000000 -> 0x4000000000000000.
- 0x80000000*0x00000001 -> 0xFFFFFFFF80000000.
REQ-031 start pulsed with new operands at edge 10 of a RUN -> ignored; first result unchanged, busy stays high, exactly one done.
REQ-032 Back-to-back: start held high through DONE -> second op accepted in the done cycle, second done exactly 33 edges later, products correct.
REQ-033 rst_n low at edge 15 of a RUN -> no done pulse, product=0; a following start completes correctly.
